alu_driver: RTL and testbench

ALU_DRIVER -- requirements
Module: alu_driver

---
 rtl/alu_driver_pkg.sv | 31 +++
 rtl/alu_driver_alu.sv | 33 +++
 rtl/alu_driver.sv | 122 ++++++++++++
 tb/tb_alu_driver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_driver_pkg.sv
// Shared constants for the ALU driver: ALUOp codes, MIPS R-type funct codes,
// FSM state encoding and the decoded-operation record.
package alu_driver_pkg;

  localparam logic [2:0] ALUOP_ADD = 3'd0;
  localparam logic [2:0] ALUOP_SUB = 3'd1;
  localparam logic [2:0] ALUOP_AND = 3'd2;
  localparam logic [2:0] ALUOP_OR  = 3'd3;
  localparam logic [2:0] ALUOP_SRL = 3'd4;
  localparam logic [2:0] ALUOP_SRA = 3'd5;
  localparam logic [2:0] ALUOP_BAD = 3'd7;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_SRA = 6'h03;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [2:0] aluop;
    logic       err;
  } dec_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/alu_driver_alu.sv
// Combinational ALU: C = f(A, B, ALUOp). Shift amounts use all 32 bits of B,
// so any amount of 32 or more saturates instead of wrapping modulo 32.
module alu_driver_alu
  import alu_driver_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  aluop,
  output logic [31:0] c
);

  logic big_shift;
  logic [31:0] srl_res;
  logic [31:0] sra_res;

  assign big_shift = |b[31:5];
  assign srl_res   = big_shift ? 32'd0 : (a >> b[4:0]);
  assign sra_res   = big_shift ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);

  always_comb begin
    c = 32'd0;
    case (aluop)
      ALUOP_ADD: c = a + b;
      ALUOP_SUB: c = a - b;
      ALUOP_AND: c = a & b;
      ALUOP_OR:  c = a | b;
      ALUOP_SRL: c = srl_res;
      ALUOP_SRA: c = sra_res;
      default:   c = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_driver.sv
// Issuing side of the ALU interface: decodes funct, sequences one operation
// through the ALU and holds the result until the consumer takes it.
// Optional statistics counters are built only with ALU_DRIVER_STATS_EN.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// EXEC  | operands latched, ALU output registered this cycle
// DONE  | result presented (out_valid=1) until out_ready
module alu_driver
  import alu_driver_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_err
`ifdef ALU_DRIVER_STATS_EN
  ,
  output logic [15:0] op_count,
  output logic [15:0] err_count
`endif
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic        err_q;
  logic [31:0] alu_c;
  logic        accept;
  dec_t        dec;

  always_comb begin
    dec = '{aluop: ALUOP_BAD, err: 1'b1};
    case (in_funct)
      FUNCT_ADD: dec = '{aluop: ALUOP_ADD, err: 1'b0};
      FUNCT_SUB: dec = '{aluop: ALUOP_SUB, err: 1'b0};
      FUNCT_AND: dec = '{aluop: ALUOP_AND, err: 1'b0};
      FUNCT_OR:  dec = '{aluop: ALUOP_OR,  err: 1'b0};
      FUNCT_SRL: dec = '{aluop: ALUOP_SRL, err: 1'b0};
      FUNCT_SRA: dec = '{aluop: ALUOP_SRA, err: 1'b0};
      default:   dec = '{aluop: ALUOP_BAD, err: 1'b1};
    endcase
  end

  assign in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = in_valid ? ST_EXEC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 3'd0;
      err_q <= 1'b0;
    end else if (accept) begin
      a_q   <= in_a;
      b_q   <= in_b;
      op_q  <= dec.aluop;
      err_q <= dec.err;
    end
  end

  alu_driver_alu u_alu (
    .a     (a_q),
    .b     (b_q),
    .aluop (op_q),
    .c     (alu_c)
  );

  // Result registers only move in EXEC, which keeps them frozen through DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_result <= 32'd0;
      out_err    <= 1'b0;
    end else if (state == ST_EXEC) begin
      out_result <= alu_c;
      out_err    <= err_q;
    end
  end

`ifdef ALU_DRIVER_STATS_EN
  logic [15:0] op_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_cnt_q  <= 16'd0;
      err_cnt_q <= 16'd0;
    end else if (accept) begin
      if (op_cnt_q != CNT_MAX) op_cnt_q <= op_cnt_q + 16'd1;
      if (dec.err && (err_cnt_q != CNT_MAX)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign op_count  = op_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// Randomized self-checking bench for alu_driver against a plain-arithmetic
// reference model; statistics checks compile in with ALU_DRIVER_STATS_EN.
module tb_alu_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;
`ifdef ALU_DRIVER_STATS_EN
  logic [15:0] op_count;
  logic [15:0] err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ops  = 0;
  int exp_errs = 0;

  always #5 clk = ~clk;

  alu_driver dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct   (in_funct),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
`ifdef ALU_DRIVER_STATS_EN
    ,
    .op_count   (op_count),
    .err_count  (err_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // {err, result} computed from the funct rules with 64-bit arithmetic
  function automatic logic [32:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua;
    longint          sa;
    logic [31:0]     r;
    logic            e;
    ua = longint'(a) & 64'hFFFF_FFFF;
    sa = longint'($signed(a));
    e  = 1'b0;
    case (f)
      6'h20: r = a + b;
      6'h22: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h02: r = (b >= 32) ? 32'd0 : 32'(ua >> b);
      6'h03: r = (b >= 32) ? (a[31] ? 32'hFFFF_FFFF : 32'd0) : 32'(sa >>> b);
      default: begin r = 32'd0; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  // Presents a request (from IDLE or DONE), checks EXEC and the result,
  // then holds out_ready low for 'stall' cycles. Returns in DONE.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [32:0] e;
    e = model(f, a, b);
    in_valid  = 1'b1;
    in_funct  = f;
    in_a      = a;
    in_b      = b;
    out_ready = 1'b1;
    #1;
    check("accept_in_ready", in_ready, 1);
    if (exp_ops < 65535) exp_ops++;
    if (e[32] && exp_errs < 65535) exp_errs++;
    @(negedge clk);
    in_valid  = 1'b0;
    in_funct  = 6'($urandom);
    in_a      = $urandom;
    in_b      = $urandom;
    out_ready = 1'b0;
    #1;
    check("exec_out_valid", out_valid, 0);
    check("exec_in_ready", in_ready, 0);
    @(negedge clk);
    check("done_out_valid", out_valid, 1);
    check("result", out_result, e[31:0]);
    check("err", out_err, e[32]);
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'($urandom);
      #1;
      check("stall_in_ready", in_ready, 0);
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_result", out_result, e[31:0]);
      check("stall_err", out_err, e[32]);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  task automatic check_stats(input string tag);
`ifdef ALU_DRIVER_STATS_EN
    check({tag, "_op_count"}, op_count, exp_ops);
    check({tag, "_err_count"}, err_count, exp_errs);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] functs [8];
    logic [5:0] f;
    logic [31:0] ra, rb;
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h02, 6'h03, 6'h2A, 6'h00};

    reset = 1'b1; in_valid = 1'b0; in_funct = 6'd0; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_err", out_err, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check_stats("rst");

    issue(6'h2A, 32'd5, 32'd3, 0);
    check_stats("illegal");
    drain();

    issue(6'h20, 32'hFFFF_FFFF, 32'd1, 0);
    drain();
    issue(6'h03, 32'h8000_0000, 32'd4, 0);
    drain();
    issue(6'h03, 32'h8000_0000, 32'd40, 0);
    drain();
    issue(6'h02, 32'h8000_0000, 32'd32, 0);
    drain();

    // back-pressure, then a same-cycle accept from DONE
    issue(6'h25, 32'h1234_0000, 32'h0000_5678, 5);
    issue(6'h22, 32'd7, 32'd9, 0);
    drain();

    // reset during EXEC discards the pending operation
    in_valid = 1'b1; in_funct = 6'h20; in_a = 32'd1; in_b = 32'd2; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_exec_out_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_ops = 0;
    exp_errs = 0;
    #1;
    check("rst_exec_in_ready", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_exec_no_valid", out_valid, 0);
    end
    check_stats("rst_exec");
    issue(6'h25, 32'h0000_00F0, 32'h0000_000F, 0);
    drain();

    for (int i = 0; i < 300; i++) begin
      f  = functs[$urandom_range(0, 7)];
      if (f == 6'h00) f = 6'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      issue(f, ra, rb, $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();
    check_stats("random");

`ifdef ALU_DRIVER_STATS_EN
    force dut.op_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.op_cnt_q;
    exp_ops = 65534;
    issue(6'h20, 32'd1, 32'd1, 0);
    check_stats("sat_reach");
    issue(6'h2A, 32'd1, 32'd1, 0);
    check_stats("sat_hold");
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
